// File: rtl/dff_share_arbiter_if.sv
// Requester-side bus for the shared-register arbiter: per-requester valid/ready/data,
// clear strobe and the shared register view.
interface dff_share_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   clr;
  logic [WIDTH-1:0]       q;
  logic [IdxW-1:0]        q_owner;
  logic                   q_valid;
  logic                   busy;

  modport master (
    output req_valid, req_data, clr,
    input  req_ready, q, q_owner, q_valid, busy
  );

  modport slave (
    input  req_valid, req_data, clr,
    output req_ready, q, q_owner, q_valid, busy
  );
endinterface

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters, with a
// post-write lock of HOLD_CYC cycles so downstream logic sees a stable q.
module dff_share_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HOLD_CYC = 2
) (
  input logic               clk,
  input logic               rst,
  dff_share_arbiter_if.slave bus
);
  localparam int unsigned     IdxW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IdxW:0]   NReqW    = (IdxW + 1)'(N_REQ);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_REQ - 1);
  localparam logic [7:0]      HoldInit = (HOLD_CYC == 0) ? 8'd0 : 8'(HOLD_CYC - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic            q_valid_q, q_valid_d;

  logic            win_found;
  logic [IdxW-1:0] win_idx;
  logic [IdxW:0]   cand;
  logic [WIDTH-1:0] sel_data;
  logic            write_fire;

  // Rotating priority scan starting at rr_ptr; explicit wrap keeps non-power-of-2 N_REQ legal.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(i);
      if (cand >= NReqW) cand = cand - NReqW;
      if (!win_found && bus.req_valid[cand[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == IdxW'(i)) sel_data = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign write_fire = (state_q == StLoad) && bus.req_valid[grant_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      q_q        <= '0;
      owner_q    <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      q_q        <= q_d;
      owner_q    <= owner_d;
      q_valid_q  <= q_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    q_d        = q_q;
    owner_d    = owner_q;
    q_valid_d  = bus.clr ? 1'b0 : q_valid_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d = win_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (write_fire) begin
          q_d        = sel_data;
          owner_d    = grant_q;
          q_valid_d  = 1'b1;  // a coincident clr loses to the write
          rr_ptr_d   = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
          hold_cnt_d = HoldInit;
          state_d    = (HOLD_CYC == 0) ? StIdle : StHold;
        end else begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (hold_cnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant decoded purely from registered state: no combinational path from req_valid.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == StLoad) bus.req_ready[grant_q] = 1'b1;
    bus.busy    = (state_q != StIdle);
    bus.q       = q_q;
    bus.q_owner = owner_q;
    bus.q_valid = q_valid_q;
  end
endmodule
